fifo_rd_arbiter: RTL and testbench
==================================

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of read requesters sharing one FIFO read port (2..8).
REQ-002 Parameter R_WIDTH, default 16: FIFO read word width.
REQ-003 Parameter BURST_LEN, default 4: maximum beats per grant (1..16).
REQ-004 Parameter ID_WIDTH, default $clog2(NUM_REQ): requester index width.
REQ-005 Parameter TIMEOUT, default 8: empty-stall cycles before forced release (used only under the configuration macro).
REQ-006 Port clk  input  1: single clock; all logic on posedge clk.
REQ-007 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-008 Port req  input  NUM_REQ: per-requester read request, level.
REQ-009 Port gnt  output  NUM_REQ: one-hot current owner; zero when idle.
REQ-010 Port fifo_empty  input  1: FIFO empty flag.
REQ-011 Port fifo_rd_data  input  R_WIDTH: show-ahead FIFO head word, valid combinationally while !fifo_empty.
REQ-012 Port fifo_rd_en  output  1: FIFO pop strobe.
REQ-013 Port out_data  output  R_WIDTH: registered popped word.
REQ-014 Port out_valid  output  1: out_data valid, one-cycle pulse per pop.
REQ-015 Port out_id  output  ID_WIDTH: requester index owning out_data.

Function
REQ-016 FSM states: IDLE, BURST; encoding from package.
REQ-017 IDLE: if req != 0, select the winner round-robin, starting at index last+1 mod NUM_REQ; next cycle state = BURST, gnt = one-hot(winner), beat count = 0.
REQ-018 IDLE with req == 0: remain IDLE, gnt = 0, fifo_rd_en = 0.
REQ-019 BURST: fifo_rd_en = req[owner] & !fifo_empty, combinational; no pop in IDLE under any input.
REQ-020 Each pop increments the 4-bit-safe beat counter; the pop on which count == BURST_LEN-1 ends the burst: next state IDLE, last = owner.
REQ-021 BURST with req[owner] low: next state IDLE, last = owner, no pop that cycle.
REQ-022 BURST with fifo_empty high and req[owner] high: hold state and count (stall).
REQ-023 Pop latency 1: cycle after fifo_rd_en, out_valid = 1, out_data = fifo_rd_data sampled at pop, out_id = owner; else out_valid = 0, out_data/out_id hold.
REQ-024 Minimum one IDLE cycle between bursts; a single requester asserting continuously gets BURST_LEN beats then a 1-cycle gap.
REQ-025 Changes in non-owner req during BURST have no effect until next IDLE.
REQ-026 last wraps NUM_REQ-1 -> 0; after reset last = NUM_REQ-1 so requester 0 wins first.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, gnt 0, fifo_rd_en 0, out_valid 0, out_data 0, out_id 0, count 0, last NUM_REQ-1, stall counter 0.
REQ-028 Reset mid-burst abandons the burst; no pop occurs in the reset cycle or the first cycle after release.

Configuration
REQ-029 Macro FIFO_RD_ARB_TIMEOUT_EN defined: in BURST, consecutive stall cycles (REQ-022) are counted; on reaching TIMEOUT, next state IDLE, last = owner; counter clears on any pop or leaving BURST.
REQ-030 Macro undefined: no stall counter, no TIMEOUT logic; stall persists indefinitely.

Structure
REQ-031 Package fifo_arb_pkg holds the FSM state typedef and the default constants for BURST_LEN and TIMEOUT.
REQ-032 One sub-module rr_pick: combinational round-robin picker (req, last) -> one-hot grant plus index; arbiter instantiates it once.

Verification
REQ-033 Reset, req=4'b0001, FIFO holding 6 words A..F -> gnt=0001, 4 pops, out_valid 4 cycles with A..D, out_id 0, 1 IDLE gap, then E,F.
REQ-034 req=4'b1111 held, FIFO deep -> grant order 0,1,2,3,0 with 4 beats each; out_id follows.
REQ-035 Owner 2 drops req after 2 beats -> IDLE next cycle, next grant goes to 3 (req=1111).
REQ-036 FIFO empties after 1 beat of a burst, refills 3 cycles later -> fifo_rd_en 0 while empty, burst resumes, total 4 beats.
REQ-037 With FIFO_RD_ARB_TIMEOUT_EN, TIMEOUT=8, FIFO empty for 8 cycles in BURST -> release to IDLE, next requester granted; without macro -> owner held.
REQ-038 rst_n asserted mid-burst at beat 2 -> all outputs 0 immediately; after release requester 0 wins first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default constants for the FIFO read-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_TIMEOUT   = 8;
  // Wide enough to hold BURST_LEN-1 for the largest legal burst of 16.
  localparam int BEAT_CNT_W    = 5;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after last_i
// (wrapping) wins; returns its one-hot grant and index.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                valid_o
);

  logic [ID_WIDTH-1:0] pos;

  // Scan from farthest to nearest so the nearest requester overwrites the rest.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = ID_WIDTH'((int'(last_i) + k) % NUM_REQ);
      if (req_i[pos]) begin
        gnt_o      = '0;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing one show-ahead FIFO read port.
// Optional empty-stall release enabled by defining FIFO_RD_ARB_TIMEOUT_EN.
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int R_WIDTH   = 16,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ID_WIDTH  = $clog2(NUM_REQ),
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  input  logic                fifo_empty,
  input  logic [R_WIDTH-1:0]  fifo_rd_data,
  output logic                fifo_rd_en,
  output logic [R_WIDTH-1:0]  out_data,
  output logic                out_valid,
  output logic [ID_WIDTH-1:0] out_id
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BURST_LEN - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 16 || TIMEOUT < 1)
  begin : g_param_check
    $error("fifo_rd_arbiter: parameter out of range");
  end

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [ID_WIDTH-1:0]   owner_q, owner_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [R_WIDTH-1:0]    out_data_q;
  logic                  out_valid_q;
  logic [ID_WIDTH-1:0]   out_id_q;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_valid;
  logic                  owner_req;
  logic                  pop;

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign owner_req = req[owner_q];
  assign pop       = (state_q == BURST) && owner_req && !fifo_empty;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    stall_d = '0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_valid) begin
          state_d = BURST;
          gnt_d   = pick_gnt;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BURST: begin
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
          cnt_d   = '0;
        end else if (!fifo_empty) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = owner_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
`ifdef FIFO_RD_ARB_TIMEOUT_EN
          // Owner still wants data but the FIFO stays dry: give up after TIMEOUT cycles.
          stall_d = stall_q + 1'b1;
          if (stall_q == STALL_W'(TIMEOUT - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = owner_q;
            cnt_d   = '0;
            stall_d = '0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_RD_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= pop;
      if (pop) begin
        out_data_q <= fifo_rd_data;
        out_id_q   <= owner_q;
      end
    end
  end

  assign gnt        = gnt_q;
  assign fifo_rd_en = pop;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_id     = out_id_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Scoreboard bench for fifo_rd_arbiter: a burst-level reference model predicts
// grants and pops; a monitor matches each out_valid beat against the queue.
module tb_fifo_rd_arbiter;

  localparam int N         = 4;
  localparam int RW        = 16;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  gnt;
  logic          fifo_empty = 1'b1;
  logic [RW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic [1:0]    out_id;

  fifo_rd_arbiter #(
    .NUM_REQ   (N),
    .R_WIDTH   (RW),
    .BURST_LEN (BURST_LEN),
    .ID_WIDTH  (2),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .gnt          (gnt),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_id       (out_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [1:0]    id;
  } exp_t;

  exp_t          sb[$];
  logic [RW-1:0] fifo_q[$];
  int            total = 0;
  int            bad = 0;

  // Reference model: who owns the port, beats delivered, last winner.
  bit m_busy;
  int m_owner, m_beats, m_last, m_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_last = N - 1; m_stall = 0;
  endtask

  task automatic model_release();
    m_busy = 0; m_last = m_owner; m_stall = 0;
  endtask

  task automatic model_advance(input logic [N-1:0] r, input bit pop);
    if (!m_busy) begin
      if (r != 0) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (r[c]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1; m_beats = 0; m_stall = 0;
      end
    end else if (!r[m_owner]) begin
      model_release();
    end else if (pop) begin
      m_beats++;
      m_stall = 0;
      if (m_beats == BURST_LEN) model_release();
    end else begin
`ifdef FIFO_RD_ARB_TIMEOUT_EN
      m_stall++;
      if (m_stall == TIMEOUT) model_release();
`endif
    end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(RW'($urandom));
  endtask

  // One clock of stimulus: drive inputs, predict, compare, queue expected beat.
  task automatic step(input logic [N-1:0] r, input bit force_empty);
    logic [N-1:0] exp_gnt;
    bit exp_pop, dut_pop;
    @(negedge clk);
    req          = r;
    fifo_empty   = force_empty || (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 16'hDEAD;
    #1;
    exp_gnt = m_busy ? N'(1 << m_owner) : '0;
    exp_pop = m_busy && r[m_owner] && !fifo_empty;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("rd_en", 32'(fifo_rd_en), 32'(exp_pop));
    if (exp_pop) sb.push_back({fifo_rd_data, 2'(m_owner)});
    $display("cyc t=%0t req=%b empty=%0d gnt=%b rd_en=%0d", $time, r, fifo_empty, gnt, fifo_rd_en);
    dut_pop = fifo_rd_en;
    model_advance(r, exp_pop);
    @(posedge clk);
    if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'h0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_out_data"}, 32'(out_data), 32'h0);
    check({tag, "_out_id"}, 32'(out_id), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    req   = '0;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    sb.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every delivered beat must match the oldest predicted beat.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(out_valid), 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_id", 32'(out_id), 32'(e.id));
        $display("beat t=%0t data=%h id=%0d", $time, out_data, out_id);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs_zero("post_rst");

    // Single requester, six words A..F: 4 beats, gap, 2 beats.
    for (int i = 0; i < 6; i++) fifo_q.push_back(16'hA000 + 16'(i));
    for (int i = 0; i < 16; i++) step(4'b0001, 0);

    // All requesting with a deep FIFO: rotation 0,1,2,3,0.
    fill(60);
    for (int i = 0; i < 30; i++) step(4'b1111, 0);

    // Owner 2 drops its request after two beats.
    fill(40);
    for (int i = 0; i < 40; i++)
      step((m_busy && m_owner == 2 && m_beats == 2) ? 4'b1011 : 4'b1111, 0);

    // FIFO runs dry after one beat and refills three cycles later.
    for (int i = 0; i < 6; i++) step(4'b0000, 0);
    fifo_q.delete();
    fill(10);
    for (int i = 0; i < 10 && !(m_busy && m_beats == 1); i++) step(4'b0001, 0);
    for (int i = 0; i < 3; i++) step(4'b0001, 1);
    for (int i = 0; i < 8; i++) step(4'b0001, 0);

    // Long empty stall with another requester waiting.
    for (int i = 0; i < 6; i++) step(4'b0000, 0);
    fill(20);
    for (int i = 0; i < 10 && !m_busy; i++) step(4'b0011, 0);
    for (int i = 0; i < 12; i++) step(4'b0011, 1);
    for (int i = 0; i < 10; i++) step(4'b0011, 0);

    // Reset in the middle of a burst; requester 0 must win afterwards.
    for (int i = 0; i < 6; i++) step(4'b0000, 1);
    fill(20);
    for (int i = 0; i < 10 && !(m_busy && m_beats == 2); i++) step(4'b0001, 0);
    do_reset();
    for (int i = 0; i < 12; i++) step(4'b1111, 0);

    // Randomised traffic.
    begin
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < 400; i++) begin
        if (i % 7 == 0) r = N'($urandom_range(0, 15));
        if (fifo_q.size() < 4) fill($urandom_range(0, 8));
        step(r, $urandom_range(0, 3) == 0);
      end
    end

    for (int i = 0; i < 4; i++) step(4'b0000, 0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
